// File: rtl/axi_lite_sram_if.sv
// AXI4-Lite read/write channel bundle between the LSU (master) and the SRAM responder (slave).
interface axi_lite_sram_if;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;

   modport master (
      output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );

   modport slave (
      input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
      output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
   );
endinterface

// File: rtl/axi_lite_sram.sv
// AXI4-Lite word-organised SRAM responder: one transaction at a time, fixed programmable
// read/write latency, DECERR for addresses outside the backed window.
module axi_lite_sram #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 4096,
   parameter int          RD_LATENCY  = 1,
   parameter int          WR_LATENCY  = 1
) (
   input logic            clock,
   input logic            reset,
   axi_lite_sram_if.slave bus
);

   localparam int IW   = $clog2(DEPTH_WORDS);
   localparam int MAXL = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   localparam int CW   = (MAXL > 1) ? $clog2(MAXL) : 1;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [31:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [31:0]   rdata_q;
   logic [1:0]    rresp_q, bresp_q;
   logic          have_aw_q, have_w_q;
   logic          ar_rdy, aw_rdy, w_rdy;
   logic          ar_hs, aw_hs, w_hs;
   logic          last_wait, addr_hit;
   logic [IW-1:0] addr_idx;

   logic [31:0]   mem [DEPTH_WORDS];

   // 64-bit compare so a window ending at 4 GiB cannot wrap
   function automatic logic in_range(input logic [31:0] a);
      return (64'(a) >= 64'(ADDR_BASE)) &&
             (64'(a) < 64'(ADDR_BASE) + 64'(DEPTH_WORDS) * 64'd4);
   endfunction

   function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
      return IW'((a - ADDR_BASE) >> 2);
   endfunction

   assign addr_hit  = in_range(addr_q);
   assign addr_idx  = word_idx(addr_q);
   assign last_wait = (cnt_q == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      ar_rdy  = 1'b0;
      aw_rdy  = 1'b0;
      w_rdy   = 1'b0;
      case (state_q)
         IDLE: begin
            ar_rdy = 1'b1;
            aw_rdy = !bus.arvalid;
            w_rdy  = !bus.arvalid;
         end
         WR_COLLECT: begin
            aw_rdy = !have_aw_q;
            w_rdy  = !have_w_q;
         end
         default: ;
      endcase
      ar_hs = bus.arvalid && ar_rdy;
      aw_hs = bus.awvalid && aw_rdy;
      w_hs  = bus.wvalid && w_rdy;
      case (state_q)
         IDLE: begin
            if (ar_hs)               state_d = RD_WAIT;
            else if (aw_hs && w_hs)  state_d = WR_WAIT;
            else if (aw_hs || w_hs)  state_d = WR_COLLECT;
         end
         RD_WAIT:    if (last_wait)      state_d = RD_RESP;
         RD_RESP:    if (bus.rready)     state_d = IDLE;
         WR_COLLECT: if (aw_hs || w_hs)  state_d = WR_WAIT;
         WR_WAIT:    if (last_wait)      state_d = WR_RESP;
         WR_RESP:    if (bus.bready)     state_d = IDLE;
         default:                        state_d = IDLE;
      endcase
   end

   assign bus.arready = ar_rdy;
   assign bus.awready = aw_rdy;
   assign bus.wready  = w_rdy;
   assign bus.rvalid  = (state_q == RD_RESP);
   assign bus.bvalid  = (state_q == WR_RESP);
   assign bus.rdata   = rdata_q;
   assign bus.rresp   = rresp_q;
   assign bus.bresp   = bresp_q;

   // Address register is shared: reads and writes never overlap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q     <= '0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         rdata_q   <= '0;
         rresp_q   <= RESP_OKAY;
         bresp_q   <= RESP_OKAY;
         have_aw_q <= 1'b0;
         have_w_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, WR_COLLECT: begin
               if (ar_hs) begin
                  addr_q <= bus.araddr;
                  cnt_q  <= CW'(RD_LATENCY - 1);
               end
               if (aw_hs) begin
                  addr_q    <= bus.awaddr;
                  have_aw_q <= 1'b1;
               end
               if (w_hs) begin
                  wdata_q  <= bus.wdata;
                  wstrb_q  <= bus.wstrb;
                  have_w_q <= 1'b1;
               end
               if (aw_hs || w_hs) cnt_q <= CW'(WR_LATENCY - 1);
            end
            RD_WAIT: begin
               if (last_wait) begin
                  rdata_q <= addr_hit ? mem[addr_idx] : 32'h0;
                  rresp_q <= addr_hit ? RESP_OKAY : RESP_DECERR;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            WR_WAIT: begin
               if (last_wait) begin
                  bresp_q   <= addr_hit ? RESP_OKAY : RESP_DECERR;
                  have_aw_q <= 1'b0;
                  have_w_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   // Array is deliberately outside the reset domain; contents survive reset
   always_ff @(posedge clock) begin
      if (!reset && state_q == WR_WAIT && last_wait && addr_hit) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_q[b]) mem[addr_idx][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

endmodule
